// File: rtl/interrupt_controller_pkg.sv
// Shared interrupt definitions: IRQ codes, FSM state encoding and source bit positions.
// The processor's interrupt decode imports the same package.
package interrupt_controller_pkg;

  localparam logic [1:0] IRQ_NONE  = 2'd0;
  localparam logic [1:0] IRQ_TIMER = 2'd1;
  localparam logic [1:0] IRQ_KBD   = 2'd2;
  localparam logic [1:0] IRQ_GPU   = 2'd3;

  localparam int unsigned SRC_TIMER = 0;
  localparam int unsigned SRC_KBD   = 1;
  localparam int unsigned SRC_GPU   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_e;

  // Fixed priority, highest first: GPU, then keyboard, then timer.
  function automatic logic [1:0] highest_irq(input logic [2:0] req);
    if (req[SRC_GPU])        return IRQ_GPU;
    else if (req[SRC_KBD])   return IRQ_KBD;
    else if (req[SRC_TIMER]) return IRQ_TIMER;
    else                     return IRQ_NONE;
  endfunction

endpackage

// File: rtl/interrupt_controller_interval_timer.sv
// Free-running interval counter that pulses TICK on the cycle it wraps.
// The counter holds its value while ENABLE is low.
module interval_timer #(
  parameter int unsigned TIMER_W      = 16,
  parameter int unsigned TIMER_PERIOD = 50000
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic ENABLE,
  output logic TICK
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMER_PERIOD - 1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    TICK    = 1'b0;
    if (ENABLE) begin
      if (count_q == LAST) begin
        count_d = '0;
        TICK    = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/interrupt_controller.sv
// Three-source interrupt controller: sticky pending bits, fixed-priority select and a
// request/acknowledge/end handshake FSM that presents one interrupt at a time.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned TIMER_PERIOD = 50000,
  parameter int unsigned TIMER_W      = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       KBD_VALID,
  input  logic       GPU_DONE,
  input  logic [2:0] INT_MASK,
  output logic [1:0] INT_IRQ,
  input  logic       INT_IACK,
  input  logic       INT_IEND,
  output logic [2:0] PENDING,
  output logic       OVERRUN,
  output logic       PROTO_ERR
);

  state_e     state_q, state_d;
  logic [1:0] cur_id_q, cur_id_d;
  logic [2:0] pending_q, pending_d;
  logic       overrun_q, overrun_d;
  logic       proto_err_q, proto_err_d;

  logic       tick;
  logic [2:0] src;
  logic [2:0] clr;

  interval_timer #(
    .TIMER_W      (TIMER_W),
    .TIMER_PERIOD (TIMER_PERIOD)
  ) u_timer (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .ENABLE  (ENABLE),
    .TICK    (tick)
  );

  assign src = {GPU_DONE, KBD_VALID, tick};

  always_comb begin
    state_d     = state_q;
    cur_id_d    = cur_id_q;
    proto_err_d = proto_err_q;
    clr         = 3'b000;
    if (!ENABLE) begin
      state_d  = ST_IDLE;
      cur_id_d = IRQ_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (INT_IACK || INT_IEND) proto_err_d = 1'b1;
          if (|(pending_q & INT_MASK)) begin
            cur_id_d = highest_irq(pending_q & INT_MASK);
            state_d  = ST_REQ;
          end
        end
        ST_REQ: begin
          // IACK takes precedence; a simultaneous IEND is still flagged.
          if (INT_IACK) begin
            clr     = 3'b001 << (cur_id_q - 2'd1);
            state_d = ST_SERV;
          end
          if (INT_IEND) proto_err_d = 1'b1;
        end
        ST_SERV: begin
          if (INT_IEND) begin
            cur_id_d = IRQ_NONE;
            state_d  = ST_IDLE;
          end
          if (INT_IACK) proto_err_d = 1'b1;
        end
        default: begin
          state_d  = ST_IDLE;
          cur_id_d = IRQ_NONE;
        end
      endcase
    end
  end

  // A source firing in the same cycle its bit is acknowledged re-arms it without overrun.
  always_comb begin
    pending_d = (pending_q & ~clr) | src;
    overrun_d = overrun_q | (|(src & pending_q & ~clr));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cur_id_q    <= IRQ_NONE;
      pending_q   <= 3'b000;
      overrun_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_id_q    <= cur_id_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign INT_IRQ   = (state_q == ST_IDLE) ? IRQ_NONE : cur_id_q;
  assign PENDING   = pending_q;
  assign OVERRUN   = overrun_q;
  assign PROTO_ERR = proto_err_q;

endmodule
